// File: rtl/shapool_board_supervisor_if.sv
// Core-array side bundle of the board supervisor.
//   core_ready_in  : per-core success pulse/level (core array -> supervisor)
//   core_mask_in   : per-core enable, 1 = channel supervised (static in RUN)
//   core_reset_out : active-high synchronous reset to the core array
//   ready_vec_out  : latched per-core READY flags
// master = supervisor side, slave = core-array side.
interface shapool_board_supervisor_if #(
  parameter int NUM_CORES = 4
);
  logic [NUM_CORES-1:0] core_ready_in;
  logic [NUM_CORES-1:0] core_mask_in;
  logic                 core_reset_out;
  logic [NUM_CORES-1:0] ready_vec_out;

  modport master (
    input  core_ready_in,
    input  core_mask_in,
    output core_reset_out,
    output ready_vec_out
  );

  modport slave (
    output core_ready_in,
    output core_mask_in,
    input  core_reset_out,
    input  ready_vec_out
  );
endinterface

// File: rtl/shapool_board_supervisor.sv
// Board-level supervisor for multi-core shapool builds.
// Qualifies PLL lock, sequences the core-array reset, latches per-core READY
// flags into one open-drain READY line and drives a mode-coded status LED.
//
// Ports:
//   clk_in           : system clock (PLL global output)
//   reset_in         : synchronous active-high reset
//   pll_locked_in    : PLL LOCK, asynchronous
//   cs0_n_in         : global SPI chip-select (active low, async); a falling
//                      edge marks a new job and clears the READY latches
//   cs1_n_in         : daisy SPI chip-select (active low, async); activity only
//   core_if          : core-array bundle (ready/mask in, reset/ready_vec out)
//   ready_n_oe_out   : 1 = READY pad driven low, 0 = released
//   status_led_n_out : active-low status LED
//   state_out        : 0 WAIT_LOCK, 1 STABILISE, 2 RELEASE, 3 RUN
//
// Optional feature: define SHAPOOL_SUPERVISOR_WDT_EN to add a RUN-state
// watchdog that re-pulses the core reset after 2^WDT_LOG2-1 idle cycles.
module shapool_board_supervisor #(
  parameter int NUM_CORES          = 4,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int BLINK_LOG2         = 22,
  parameter int WDT_LOG2           = 26
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         pll_locked_in,
  input  logic                         cs0_n_in,
  input  logic                         cs1_n_in,
  shapool_board_supervisor_if.master   core_if,
  output logic                         ready_n_oe_out,
  output logic                         status_led_n_out,
  output logic [1:0]                   state_out
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILISE = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  // One counter serves both STABILISE and RELEASE; it is sized for the larger.
  localparam int CNT_SPAN = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                            LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W    = $clog2((CNT_SPAN < 2) ? 2 : CNT_SPAN);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [BLINK_LOG2-1:0]    blink_cnt;
  logic [NUM_CORES-1:0]     ready_vec;
  logic                     core_reset;
  logic [SYNC_STAGES-1:0]   lock_sync;
  logic [SYNC_STAGES-1:0]   cs0_sync;
  logic [SYNC_STAGES-1:0]   cs1_sync;
  logic                     cs0_prev;
  logic                     lock;
  logic                     cs0_s;
  logic                     cs0_fall;

  assign lock     = lock_sync[SYNC_STAGES-1];
  assign cs0_s    = cs0_sync[SYNC_STAGES-1];
  assign cs0_fall = cs0_prev & ~cs0_s;

`ifdef SHAPOOL_SUPERVISOR_WDT_EN
  logic                cs1_prev;
  logic [WDT_LOG2-1:0] wdt_cnt;
  logic                cs_activity;
  assign cs_activity = (cs0_prev ^ cs0_s) | (cs1_prev ^ cs1_sync[SYNC_STAGES-1]);
`else
  // cs1_n is synchronised but has no consumer in this build.
`endif

  // Synchronisers: chip-selects idle high, lock idles low.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      lock_sync <= '0;
      cs0_sync  <= '1;
      cs1_sync  <= '1;
      cs0_prev  <= 1'b1;
`ifdef SHAPOOL_SUPERVISOR_WDT_EN
      cs1_prev  <= 1'b1;
`endif
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_locked_in};
      cs0_sync  <= {cs0_sync[SYNC_STAGES-2:0], cs0_n_in};
      cs1_sync  <= {cs1_sync[SYNC_STAGES-2:0], cs1_n_in};
      cs0_prev  <= cs0_s;
`ifdef SHAPOOL_SUPERVISOR_WDT_EN
      cs1_prev  <= cs1_sync[SYNC_STAGES-1];
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state            <= WAIT_LOCK;
      cnt              <= '0;
      blink_cnt        <= '0;
      ready_vec        <= '0;
      core_reset       <= 1'b1;
      ready_n_oe_out   <= 1'b0;
      status_led_n_out <= 1'b1;
`ifdef SHAPOOL_SUPERVISOR_WDT_EN
      wdt_cnt          <= '0;
`endif
    end else begin
      blink_cnt      <= blink_cnt + 1'b1;
      ready_n_oe_out <= |ready_vec;
`ifdef SHAPOOL_SUPERVISOR_WDT_EN
      wdt_cnt        <= '0;
`endif

      case (state)
        WAIT_LOCK: status_led_n_out <= 1'b1;
        STABILISE,
        RELEASE:   status_led_n_out <= blink_cnt[BLINK_LOG2-3];
        default:   status_led_n_out <= ready_n_oe_out ? blink_cnt[BLINK_LOG2-1] : 1'b0;
      endcase

      case (state)
        WAIT_LOCK: begin
          core_reset <= 1'b1;
          ready_vec  <= '0;
          cnt        <= '0;
          if (lock) state <= STABILISE;
        end
        STABILISE: begin
          if (!lock) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STAB_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!lock) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (!lock) begin
            state      <= WAIT_LOCK;
            core_reset <= 1'b1;
            ready_vec  <= '0;
          end else begin
            // Set term is OR-ed after the clear so a result landing on the
            // clear cycle survives.
            ready_vec <= (ready_vec & ~{NUM_CORES{cs0_fall}}) |
                         (core_if.core_ready_in & core_if.core_mask_in);
`ifdef SHAPOOL_SUPERVISOR_WDT_EN
            if (cs_activity || ready_n_oe_out) begin
              wdt_cnt <= '0;
            end else if (&wdt_cnt) begin
              state      <= RELEASE;
              core_reset <= 1'b1;
              ready_vec  <= '0;
              cnt        <= '0;
            end else begin
              wdt_cnt <= wdt_cnt + 1'b1;
            end
`endif
          end
        end
      endcase
    end
  end

  assign core_if.core_reset_out = core_reset;
  assign core_if.ready_vec_out  = ready_vec;
  assign state_out              = state;

endmodule

// File: tb/tb_shapool_board_supervisor.sv
module tb_shapool_board_supervisor;
  localparam int N    = 4;
  localparam int LSC  = 8;
  localparam int RHC  = 4;
  localparam int SYNC = 2;
  localparam int BL   = 4;
  localparam int WL   = 6;

  logic       clk = 1'b0;
  logic       reset_in = 1'b1;
  logic       pll = 1'b0;
  logic       cs0 = 1'b1;
  logic       cs1 = 1'b1;
  logic       oe;
  logic       led;
  logic [1:0] st;

  shapool_board_supervisor_if #(.NUM_CORES(N)) core_if();

  shapool_board_supervisor #(
    .NUM_CORES(N), .LOCK_STABLE_CYCLES(LSC), .RESET_HOLD_CYCLES(RHC),
    .SYNC_STAGES(SYNC), .BLINK_LOG2(BL), .WDT_LOG2(WL)
  ) dut (
    .clk_in(clk), .reset_in(reset_in), .pll_locked_in(pll),
    .cs0_n_in(cs0), .cs1_n_in(cs1), .core_if(core_if),
    .ready_n_oe_out(oe), .status_led_n_out(led), .state_out(st)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] ready;
    logic         cs0;
    logic [N-1:0] exp_vec;
    logic         exp_oe;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int     exp_st, g, n, cnt_rel, bad;
    bit     seen0, seen1, fall;
    bit     q[$];
    logic [N-1:0] mvec, mask, r;
    logic   eoe;

    // mask 1011: bit 2 is disabled, so ready on bit 2 must never latch.
    tbl[0]  = '{4'b0100, 1'b1, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0010, 1'b1, 4'b0010, 1'b0};
    tbl[2]  = '{4'b0000, 1'b1, 4'b0010, 1'b1};
    tbl[3]  = '{4'b1001, 1'b1, 4'b1011, 1'b1};
    tbl[4]  = '{4'b0000, 1'b0, 4'b1011, 1'b1};
    tbl[5]  = '{4'b0000, 1'b0, 4'b1011, 1'b1};
    tbl[6]  = '{4'b0001, 1'b0, 4'b0001, 1'b1};  // clear cycle, bit 0 set wins
    tbl[7]  = '{4'b0000, 1'b0, 4'b0001, 1'b1};
    tbl[8]  = '{4'b0000, 1'b1, 4'b0001, 1'b1};
    tbl[9]  = '{4'b0000, 1'b1, 4'b0001, 1'b1};
    tbl[10] = '{4'b0100, 1'b0, 4'b0001, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 4'b0001, 1'b1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    core_if.core_ready_in = '0;
    core_if.core_mask_in  = 4'b1011;

    // Reset state
    @(negedge clk);
    repeat (3) cyc();
    chk("rst_state", st, 0);
    chk("rst_core_reset", core_if.core_reset_out, 1);
    chk("rst_ready_vec", core_if.ready_vec_out, 0);
    chk("rst_oe", oe, 0);
    chk("rst_led", led, 1);
    reset_in = 1'b0;
    repeat (7) cyc();
    chk("wait_lock_state", st, 0);
    chk("wait_lock_led", led, 1);

    // Startup: lock applied before edge 1 -> STABILISE at 3, RELEASE at 11, RUN at 15
    pll = 1'b1;
    seen0 = 0; seen1 = 0;
    for (int e = 1; e <= 16; e++) begin
      cyc();
      exp_st = (e < SYNC + 1) ? 0 : (e < SYNC + 1 + LSC) ? 1 :
               (e < SYNC + 1 + LSC + RHC) ? 2 : 3;
      chk($sformatf("startup_state_e%0d", e), st, exp_st);
      chk($sformatf("startup_core_reset_e%0d", e), core_if.core_reset_out, (exp_st != 3));
      if (st == 1 && e > SYNC + 2) begin
        if (led) seen1 = 1; else seen0 = 1;
      end
    end
    chk("led_fast_blink", {seen1, seen0}, 2'b11);

    // Lock glitch during STABILISE: qualification restarts
    reset_in = 1'b1;
    repeat (2) cyc();
    reset_in = 1'b0;
    g = 6;
    for (int e = 1; e <= g + 3 + LSC + RHC; e++) begin
      cyc();
      if (e < 3)                         exp_st = 0;
      else if (e < g + 2)                exp_st = 1;
      else if (e == g + 2)               exp_st = 0;
      else if (e < g + 3 + LSC)          exp_st = 1;
      else if (e < g + 3 + LSC + RHC)    exp_st = 2;
      else                               exp_st = 3;
      chk($sformatf("glitch_state_e%0d", e), st, exp_st);
      if (e == g - 1) pll = 1'b0;
      if (e == g)     pll = 1'b1;
    end

    // Ready latching table
    for (int i = 0; i < 14; i++) begin
      core_if.core_ready_in = tbl[i].ready;
      cs0 = tbl[i].cs0;
      cyc();
      chk($sformatf("tbl_vec_%0d", i), core_if.ready_vec_out, tbl[i].exp_vec);
      chk($sformatf("tbl_oe_%0d", i), oe, tbl[i].exp_oe);
    end
    core_if.core_ready_in = '0;
    repeat (2) cyc();
    chk("led_solid_on", led, 0);
    chk("run_core_reset_low", core_if.core_reset_out, 0);

    // Slow blink while READY asserted
    core_if.core_ready_in = 4'b0001;
    cyc();
    core_if.core_ready_in = '0;
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (i >= 2) begin
        if (led) seen1 = 1; else seen0 = 1;
      end
    end
    chk("slow_blink_oe", oe, 1);
    chk("led_slow_blink", {seen1, seen0}, 2'b11);

    // Lock loss in RUN with ready_vec = 0001
    pll = 1'b0;
    cyc(); chk("lockloss_e1_state", st, 3);
    cyc(); chk("lockloss_e2_state", st, 3);
    cyc();
    chk("lockloss_state", st, 0);
    chk("lockloss_core_reset", core_if.core_reset_out, 1);
    chk("lockloss_vec", core_if.ready_vec_out, 0);
    chk("lockloss_oe_lag", oe, 1);
    cyc();
    chk("lockloss_oe", oe, 0);
    chk("lockloss_led", led, 1);

    // Relock, then randomized RUN traffic against the model
    pll = 1'b1;
    n = 0;
    while (st != 3 && n < 60) begin cyc(); n++; end
    chk("relock_run", st, 3);
    mask = 4'($urandom_range(0, 15));
    core_if.core_mask_in = mask;
    mvec = '0;
    repeat (SYNC + 1) q.push_back(1'b1);
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 5) == 0) cs0 = ~cs0;
      core_if.core_ready_in = r;
      q.push_back(cs0);
      // Synchronised cs0 lags the pin by SYNC edges; a fall seen there clears next edge.
      fall = q[q.size() - 2 - SYNC] && !q[q.size() - 1 - SYNC];
      q.pop_front();
      eoe  = |mvec;
      mvec = (fall ? '0 : mvec) | (r & mask);
      cyc();
      chk($sformatf("rand_vec_%0d", i), core_if.ready_vec_out, mvec);
      chk($sformatf("rand_oe_%0d", i), oe, eoe);
    end

    // All-zero mask: READY never asserts
    core_if.core_mask_in = '0;
    core_if.core_ready_in = '0;
    cs0 = 1'b1; repeat (4) cyc();
    cs0 = 1'b0; repeat (4) cyc();
    cs0 = 1'b1; repeat (4) cyc();
    core_if.core_ready_in = 4'hF;
    repeat (5) cyc();
    chk("zero_mask_vec", core_if.ready_vec_out, 0);
    chk("zero_mask_oe", oe, 0);
    chk("zero_mask_run", st, 3);
    core_if.core_ready_in = '0;

    // Idle RUN with no chip-select activity
`ifdef SHAPOOL_SUPERVISOR_WDT_EN
    n = 0;
    while (st != 2 && n < 80) begin cyc(); n++; end
    chk("wdt_release", st, 2);
    cnt_rel = 0;
    while (st == 2 && cnt_rel < 20) begin
      if (core_if.core_reset_out !== 1'b1) errors++;
      cnt_rel++;
      cyc();
    end
    chk("wdt_hold_cycles", cnt_rel, RHC);
    chk("wdt_back_run", st, 3);
    chk("wdt_core_reset_low", core_if.core_reset_out, 0);
`else
    bad = 0;
    repeat (80) begin
      cyc();
      if (st != 3) bad++;
    end
    chk("no_wdt_stays_run", bad, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shapool_board_supervisor.md
Name: shapool_board_supervisor

Overview:
- Board-level supervisor for multi-core shapool builds; sits between the PLL/board pins and the `top` core array.
- Qualifies PLL lock and sequences the core reset.
- Synchronises SPI chip-selects and latches per-core READY flags into one open-drain READY line.
- Drives a mode-coded status LED.
- Generalises the single-core HX8K wrapper to NUM_CORES channels with lock-loss recovery.

Parameters:
- NUM_CORES, 4, number of core channels supervised (1..32).
- LOCK_STABLE_CYCLES, 1024, consecutive cycles pll_locked_in must be high before release.
- RESET_HOLD_CYCLES, 16, cycles core_reset_out stays high after lock qualifies.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input (min 2).
- BLINK_LOG2, 22, LED slow-blink period = 2^BLINK_LOG2 cycles; fast blink = 2^(BLINK_LOG2-2).
- WDT_LOG2, 26, watchdog timeout = 2^WDT_LOG2 cycles (used only with the optional feature).

Ports:
- clk_in  input  1  system clock (PLL global output).
- reset_in  input  1  synchronous, active-high reset.
- pll_locked_in  input  1  PLL LOCK, asynchronous.
- cs0_n_in  input  1  global SPI chip-select, active low, asynchronous.
- cs1_n_in  input  1  daisy SPI chip-select, active low, asynchronous.
- core_ready_in  input  NUM_CORES  per-core success pulse/level, clk_in domain.
- core_mask_in  input  NUM_CORES  1 = channel enabled; static during RUN.
- core_reset_out  output  1  active-high synchronous reset to the core array.
- ready_n_oe_out  output  1  1 = pad driven low (READY asserted); 0 = released (hi-Z).
- ready_vec_out  output  NUM_CORES  latched READY flags.
- status_led_n_out  output  1  active-low status LED.
- state_out  output  2  FSM state: 0 WAIT_LOCK, 1 STABILISE, 2 RELEASE, 3 RUN.

Behaviour:
- Clock and reset: one clock, clk_in. reset_in is synchronous, active-high.
- Reset values: state WAIT_LOCK, core_reset_out=1, ready_vec_out=0, ready_n_oe_out=0, status_led_n_out=1, all counters 0, synchroniser stages 1 for cs inputs and 0 for lock.
- Synchronisers: pll_locked_in, cs0_n_in and cs1_n_in each pass SYNC_STAGES flops. Each is referred to below by its synchronised value.
- WAIT_LOCK:
  - core_reset_out=1.
  - lock=1 -> STABILISE, counter cleared.
- STABILISE:
  - Counter increments while lock=1.
  - lock=0 -> WAIT_LOCK.
  - Counter reaches LOCK_STABLE_CYCLES-1 with lock=1 -> RELEASE, counter cleared.
- RELEASE:
  - core_reset_out=1 for exactly RESET_HOLD_CYCLES cycles, then -> RUN.
  - core_reset_out=0 from the first RUN cycle.
- RUN:
  - core_reset_out=0.
  - Per-core ready latch: ready_vec_out[i] sets when core_ready_in[i] & core_mask_in[i]. It is sticky.
  - Latches clear on the cycle after a synchronised falling edge of cs0_n (new job broadcast).
  - Set and clear in the same cycle: set wins, so a result is never lost.
  - ready_n_oe_out = registered OR of ready_vec_out (1-cycle latency from latch).
- Lock loss: lock=0 in STABILISE, RELEASE or RUN -> WAIT_LOCK next cycle.
  - core_reset_out=1 and ready_vec_out cleared on that same transition.
- Counters: sized $clog2(max(param,2)); no wrap in STABILISE or RELEASE (exit occurs first). The blink counter free-runs and wraps.
- LED pattern:
  - WAIT_LOCK: off.
  - STABILISE and RELEASE: fast blink.
  - RUN with ready_n_oe_out=0: solid on.
  - RUN with ready_n_oe_out=1: slow blink.
- cs1_n: synchronised for activity detection only, no data path.
- Mask of all zeros: RUN still reached; READY never asserts.

Optional Feature:
- Macro: SHAPOOL_SUPERVISOR_WDT_EN.
- Defined:
  - A watchdog counter runs in RUN and clears on any synchronised edge of cs0_n or cs1_n, or while ready_n_oe_out=1.
  - At 2^WDT_LOG2-1 the FSM returns to RELEASE: core reset re-pulsed for RESET_HOLD_CYCLES and ready_vec_out cleared.
- Undefined: no watchdog logic; RUN is left only on lock loss or reset_in.

Test Plan:
- Reset, then lock rises at cycle 10 (LOCK_STABLE_CYCLES=8, RESET_HOLD_CYCLES=4, SYNC_STAGES=2) -> STABILISE at 13, RELEASE at 21, RUN and core_reset_out=0 at 25.
- Lock glitches low for 1 cycle during STABILISE -> return to WAIT_LOCK, counter restarts, RUN delayed by the full qualification period.
- In RUN, mask=4'b1011, core_ready_in=4'b0100 then 4'b0010 -> ready_vec_out=4'b0010 only; ready_n_oe_out=1 one cycle later; LED slow-blinks.
- cs0_n falls while core_ready_in[0]=1 on the clear cycle -> ready_vec_out[0] stays 1, other bits clear.
- Lock drops in RUN with ready_vec_out=4'b0001 -> next cycle core_reset_out=1, ready_vec_out=0, ready_n_oe_out=0 one cycle later, state_out=0.
- SHAPOOL_SUPERVISOR_WDT_EN with WDT_LOG2=6: no cs edges for 64 cycles in RUN -> state RELEASE, core_reset_out high 4 cycles. Without the macro -> stays in RUN.
